// File: rtl/dram_arbiter_if.sv
// AXI-style bus between the DRAM arbiter (master) and the DRAM controller
// wrapper slave port. One bundle carries AW, W, B, AR and R channels.
interface dram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 8
);
  // write address
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  // write data
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  // write response
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  // read address
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  // read data
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one AXI slave port between NREQ requesters.
// One transaction in flight: a read burst or a single-beat write. Response
// beats are steered back to the requester that won the grant.
module dram_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4,
  parameter int ID_W   = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREQ-1:0]                  req_valid_i,
  input  logic [NREQ-1:0]                  req_write_i,
  output logic [NREQ-1:0]                  req_ready_o,
  input  logic [NREQ-1:0][ADDR_W-1:0]      req_addr_i,
  input  logic [NREQ-1:0][LEN_W-1:0]       req_len_i,
  input  logic [NREQ-1:0][DATA_W-1:0]      req_wdata_i,
  input  logic [NREQ-1:0][DATA_W/8-1:0]    req_wstrb_i,
  output logic [NREQ-1:0]                  rsp_valid_o,
  output logic [DATA_W-1:0]                rsp_rdata_o,
  output logic                             rsp_last_o,
  output logic                             rsp_err_o,
  dram_arbiter_if.master                   axi
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_RD, S_AW, S_W, S_B} state_t;

  state_t              state_q;
  logic [GW-1:0]       ptr_q;      // last granted requester
  logic [GW-1:0]       gnt_q;      // owner of the in-flight transaction
  logic [LEN_W:0]      cnt_q;      // read beats accepted, saturating
  logic [ADDR_W-1:0]   awaddr_q, araddr_q;
  logic [LEN_W-1:0]    arlen_q;
  logic [ID_W-1:0]     awid_q, arid_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [SW-1:0]       wstrb_q;
  logic                arvalid_q, awvalid_q, wvalid_q, bready_q, rready_q;

  logic                gnt_hit;
  logic [GW-1:0]       gnt_sel;
  int                  cand_idx;

  // Rotating priority search starting just after the last winner
  always_comb begin
    gnt_hit  = 1'b0;
    gnt_sel  = '0;
    cand_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_hit && req_valid_i[cand_idx]) begin
        gnt_hit = 1'b1;
        gnt_sel = GW'(cand_idx);
      end
    end
  end

  // Grant pulse only while idle; gated by reset so it drops asynchronously too
  always_comb begin
    req_ready_o = '0;
    if (rst && state_q == S_IDLE && gnt_hit) req_ready_o[gnt_sel] = 1'b1;
  end

  // Transaction FSM with registered channel valids/readies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= GW'(NREQ - 1);
      gnt_q     <= '0;
      cnt_q     <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      awid_q    <= '0;
      arid_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gnt_hit) begin
            ptr_q <= gnt_sel;
            gnt_q <= gnt_sel;
            if (req_write_i[gnt_sel]) begin
              // write data is latched here so it is already on WDATA
              // while AW is still pending
              awaddr_q  <= req_addr_i[gnt_sel];
              awid_q    <= ID_W'(gnt_sel);
              wdata_q   <= req_wdata_i[gnt_sel];
              wstrb_q   <= req_wstrb_i[gnt_sel];
              awvalid_q <= 1'b1;
              state_q   <= S_AW;
            end else begin
              araddr_q  <= req_addr_i[gnt_sel];
              arlen_q   <= req_len_i[gnt_sel];
              arid_q    <= ID_W'(gnt_sel);
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_RD;
          end
        end
        S_RD: begin
          if (axi.RVALID) begin
            // saturate so a runaway burst cannot alias back onto len
            if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
            if (axi.RLAST) begin
              rready_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        S_AW: begin
          if (axi.AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state_q   <= S_W;
          end
        end
        S_W: begin
          if (axi.WREADY) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (axi.BVALID) begin
            bready_q <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response steering: R beats and the B response pass straight through
  always_comb begin
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_last_o  = 1'b0;
    rsp_err_o   = 1'b0;
    if (rready_q && axi.RVALID) begin
      rsp_valid_o[gnt_q] = 1'b1;
      rsp_rdata_o        = axi.RDATA;
      rsp_last_o         = axi.RLAST;
      rsp_err_o          = (axi.RRESP != 2'b00) ||
                           (axi.RLAST && (cnt_q != {1'b0, arlen_q}));
    end else if (bready_q && axi.BVALID) begin
      rsp_valid_o[gnt_q] = 1'b1;
      rsp_last_o         = 1'b1;
      rsp_err_o          = (axi.BRESP != 2'b00);
    end
  end

  assign axi.AWID    = awid_q;
  assign axi.AWADDR  = awaddr_q;
  assign axi.AWLEN   = '0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = wstrb_q;
  assign axi.WLAST   = wvalid_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARID    = arid_q;
  assign axi.ARADDR  = araddr_q;
  assign axi.ARLEN   = arlen_q;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

  // IDs come back but only one transaction is ever outstanding
  logic unused_ids;
  assign unused_ids = ^{axi.RID, axi.BID};

endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  localparam int NREQ = 2, ADDR_W = 32, DATA_W = 32, LEN_W = 4, ID_W = 8;
  localparam int SW = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]              req_valid, req_write, req_ready, rsp_valid;
  logic [NREQ-1:0][ADDR_W-1:0]  req_addr;
  logic [NREQ-1:0][LEN_W-1:0]   req_len;
  logic [NREQ-1:0][DATA_W-1:0]  req_wdata;
  logic [NREQ-1:0][SW-1:0]      req_wstrb;
  logic [DATA_W-1:0]            rsp_rdata;
  logic                         rsp_last, rsp_err;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) axi();

  dram_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_write_i(req_write), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_len_i(req_len),
    .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_last_o(rsp_last), .rsp_err_o(rsp_err),
    .axi(axi)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  bit                busy;
  int                ptr;
  int                c_idx, c_len, beats;
  bit                c_wr, ar_done, aw_done, w_done;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [SW-1:0]     m_wstrb;
  int                m_gi;
  logic [NREQ-1:0]   e_rdy, e_rsp;
  logic [DATA_W-1:0] e_data;
  logic              e_last, e_err;

  always @(negedge clk) begin
    if (!rst) begin
      busy = 1'b0; ptr = NREQ - 1; m_wdata = '0; m_wstrb = '0;
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_valids", 64'({axi.ARVALID, axi.AWVALID, axi.WVALID, axi.RREADY, axi.BREADY}), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_wdata", 64'(axi.WDATA), 64'(0));
    end else begin
      m_gi = -1;
      if (!busy)
        for (int k = 1; k <= NREQ; k++)
          if (m_gi < 0 && req_valid[(ptr + k) % NREQ]) m_gi = (ptr + k) % NREQ;
      e_rdy = '0;
      if (m_gi >= 0) e_rdy[m_gi] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("arvalid", 64'(axi.ARVALID), 64'(busy && !c_wr && !ar_done));
      chk("rready",  64'(axi.RREADY),  64'(busy && !c_wr && ar_done));
      chk("awvalid", 64'(axi.AWVALID), 64'(busy && c_wr && !aw_done));
      chk("wvalid",  64'(axi.WVALID),  64'(busy && c_wr && aw_done && !w_done));
      chk("bready",  64'(axi.BREADY),  64'(busy && c_wr && w_done));
      chk("wdata", 64'(axi.WDATA), 64'(m_wdata));
      chk("wstrb", 64'(axi.WSTRB), 64'(m_wstrb));
      chk("size_burst", 64'({axi.ARSIZE, axi.ARBURST, axi.AWSIZE, axi.AWBURST}), 64'(10'b010_01_010_01));
      if (axi.ARVALID) begin
        chk("araddr", 64'(axi.ARADDR), 64'(c_addr));
        chk("arlen", 64'(axi.ARLEN), 64'(c_len));
        chk("arid", 64'(axi.ARID), 64'(c_idx));
      end
      if (axi.AWVALID) begin
        chk("awaddr", 64'(axi.AWADDR), 64'(c_addr));
        chk("awlen", 64'(axi.AWLEN), 64'(0));
        chk("awid", 64'(axi.AWID), 64'(c_idx));
      end
      if (axi.WVALID) chk("wlast", 64'(axi.WLAST), 64'(1));
      e_rsp = '0; e_data = '0; e_last = 1'b0; e_err = 1'b0;
      if (busy && !c_wr && ar_done && axi.RVALID) begin
        e_rsp[c_idx] = 1'b1; e_data = axi.RDATA; e_last = axi.RLAST;
        e_err = (axi.RRESP != 2'b00) || (axi.RLAST && beats != c_len);
      end
      if (busy && c_wr && w_done && axi.BVALID) begin
        e_rsp[c_idx] = 1'b1; e_last = 1'b1; e_err = (axi.BRESP != 2'b00);
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      if (e_rsp != '0) begin
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e_data));
        chk("rsp_last", 64'(rsp_last), 64'(e_last));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
      end
      if (m_gi >= 0) begin
        busy = 1'b1; ptr = m_gi; c_idx = m_gi; c_wr = req_write[m_gi];
        c_addr = req_addr[m_gi]; c_len = int'(req_len[m_gi]);
        ar_done = 1'b0; aw_done = 1'b0; w_done = 1'b0; beats = 0;
        if (c_wr) begin m_wdata = req_wdata[m_gi]; m_wstrb = req_wstrb[m_gi]; end
      end else if (busy) begin
        if (!c_wr) begin
          if (!ar_done) begin
            if (axi.ARREADY) ar_done = 1'b1;
          end else if (axi.RVALID) begin
            beats++;
            if (axi.RLAST) busy = 1'b0;
          end
        end else begin
          if (!aw_done) begin
            if (axi.AWREADY) aw_done = 1'b1;
          end else if (!w_done) begin
            if (axi.WREADY) w_done = 1'b1;
          end else if (axi.BVALID) busy = 1'b0;
        end
      end
    end
  end

  bit              s_ar_hs, s_r_hs, s_w_hs, s_b_hs;
  int              s_arlen;
  logic [NREQ-1:0] s_rdy;
  int              rd_left;
  bit              b_pend;

  always @(negedge clk) begin
    s_ar_hs = rst && axi.ARVALID && axi.ARREADY;
    s_r_hs  = rst && axi.RVALID && axi.RREADY;
    s_w_hs  = rst && axi.WVALID && axi.WREADY;
    s_b_hs  = rst && axi.BVALID && axi.BREADY;
    s_arlen = int'(axi.ARLEN);
    s_rdy   = rst ? req_ready : '0;
  end

  task automatic rand_cycle(input bit new_reqs);
    int r;
    if (s_b_hs) b_pend = 1'b0;
    if (s_w_hs) b_pend = 1'b1;
    if (s_r_hs) rd_left--;
    if (s_ar_hs) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)      rd_left = int'($urandom_range(1, s_arlen + 1));
      else if (r == 1) rd_left = s_arlen + 2;
      else             rd_left = s_arlen + 1;
    end
    axi.ARREADY = ($urandom_range(0, 2) != 0);
    axi.AWREADY = ($urandom_range(0, 2) != 0);
    axi.WREADY  = ($urandom_range(0, 2) != 0);
    if (rd_left > 0) begin
      axi.RVALID = ($urandom_range(0, 3) != 0);
      axi.RLAST  = (rd_left == 1);
      axi.RDATA  = $urandom;
      axi.RRESP  = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
    end else begin
      axi.RVALID = 1'b0;
      axi.RLAST  = 1'b0;
    end
    axi.BVALID = b_pend && ($urandom_range(0, 1) == 1);
    axi.BRESP  = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
    for (int i = 0; i < NREQ; i++) begin
      if (s_rdy[i]) req_valid[i] = 1'b0;
      if (new_reqs && !req_valid[i] && $urandom_range(0, 2) != 0) begin
        req_valid[i] = 1'b1;
        req_write[i] = ($urandom_range(0, 1) == 1);
        req_addr[i]  = $urandom;
        req_len[i]   = LEN_W'($urandom_range(0, 5));
        req_wdata[i] = $urandom;
        req_wstrb[i] = SW'($urandom);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
    req_wdata = '0; req_wstrb = '0;
    axi.AWREADY = 1'b0; axi.WREADY = 1'b0; axi.ARREADY = 1'b0;
    axi.BID = '0; axi.BRESP = '0; axi.BVALID = 1'b0;
    axi.RID = '0; axi.RDATA = '0; axi.RRESP = '0; axi.RLAST = 1'b0; axi.RVALID = 1'b0;
    rd_left = 0; b_pend = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (3) tick();
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_arvalid", 64'(axi.ARVALID), 64'(0));
    chk("reset_arsize", 64'(axi.ARSIZE), 64'(3'b010));
    chk("reset_wdata", 64'(axi.WDATA), 64'(0));
    rst = 1'b1;

    tick();
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0000_1004; req_len[0] = 4'd3;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL t1_grant: got %0h at %0t", req_ready, $time);
    end
    tick();
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h0000_2008;
    req_wdata[1] = 32'hDEAD_BEEF; req_wstrb[1] = 4'h3;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t1_arvalid", 64'(axi.ARVALID), 64'(1));
      chk("t1_araddr", 64'(axi.ARADDR), 64'(32'h0000_1004));
      chk("t1_arlen", 64'(axi.ARLEN), 64'(3));
      chk("t1_arid", 64'(axi.ARID), 64'(0));
      chk("t4_no_grant", 64'(req_ready), 64'(0));
      tick();
    end
    axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      axi.RVALID = 1'b1; axi.RDATA = 32'hA000_0000 + k; axi.RLAST = (k == 3); axi.RRESP = 2'b00;
      #1;
      chk("t1_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      chk("t1_rsp_rdata", 64'(rsp_rdata), 64'(32'hA000_0000 + k));
      chk("t1_rsp_last", 64'(rsp_last), 64'(k == 3));
      chk("t1_rsp_err", 64'(rsp_err), 64'(0));
      tick();
    end
    axi.RVALID = 1'b0; axi.RLAST = 1'b0;

    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL t2_grant: got %0h at %0t", req_ready, $time);
    end
    tick();
    req_valid[1] = 1'b0;
    #1;
    chk("t2_awvalid", 64'(axi.AWVALID), 64'(1));
    chk("t2_awid", 64'(axi.AWID), 64'(1));
    chk("t2_awlen", 64'(axi.AWLEN), 64'(0));
    chk("t2_wdata_aw", 64'(axi.WDATA), 64'(32'hDEAD_BEEF));
    chk("t2_wstrb", 64'(axi.WSTRB), 64'(4'h3));
    axi.AWREADY = 1'b1;
    tick();
    axi.AWREADY = 1'b0;
    #1;
    chk("t2_wvalid_wlast", 64'({axi.WVALID, axi.WLAST}), 64'(2'b11));
    chk("t2_wdata_w", 64'(axi.WDATA), 64'(32'hDEAD_BEEF));
    axi.WREADY = 1'b1;
    tick();
    axi.WREADY = 1'b0;
    axi.BVALID = 1'b1; axi.BRESP = 2'b00;
    #1;
    chk("t2_rsp_valid", 64'(rsp_valid), 64'(2'b10));
    chk("t2_rsp_last_err", 64'({rsp_last, rsp_err}), 64'(2'b10));
    tick();
    axi.BVALID = 1'b0;

    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h0000_3000; req_len[0] = 4'd3;
    tick();
    req_valid[0] = 1'b0; axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1; axi.RLAST = 1'b0; axi.RRESP = 2'b10; axi.RDATA = 32'h1111_1111;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_last, rsp_err} !== 4'b0101) begin
      n_fail++; $display("FAIL t5_rresp_err: got %0h at %0t", {rsp_valid, rsp_last, rsp_err}, $time);
    end
    tick();
    axi.RLAST = 1'b1; axi.RRESP = 2'b00;
    #1;
    n_chk++;
    if ({rsp_valid, rsp_last, rsp_err} !== 4'b0111) begin
      n_fail++; $display("FAIL t5_short_err: got %0h at %0t", {rsp_valid, rsp_last, rsp_err}, $time);
    end
    tick();
    axi.RVALID = 1'b0; axi.RLAST = 1'b0;
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0000_4000; req_len[1] = 4'd3;
    #1;
    n_chk++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL t5_idle_after: got %0h at %0t", req_ready, $time);
    end

    tick();
    req_valid[1] = 1'b0; axi.ARREADY = 1'b1;
    tick();
    axi.ARREADY = 1'b0;
    axi.RVALID = 1'b1; axi.RDATA = 32'h2222_2222;
    tick();
    #1 rst = 1'b0;
    #1;
    n_chk++;
    if ({axi.RREADY, rsp_valid, axi.ARVALID} !== 4'b0000) begin
      n_fail++; $display("FAIL t6_drop: got %0h at %0t", {axi.RREADY, rsp_valid, axi.ARVALID}, $time);
    end
    chk("t6_rready_drop", 64'(axi.RREADY), 64'(0));
    chk("t6_rsp_drop", 64'(rsp_valid), 64'(0));
    chk("t6_arvalid_drop", 64'(axi.ARVALID), 64'(0));
    axi.RVALID = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    req_valid = 2'b11; req_write = 2'b00;
    #1;
    n_chk++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL t6_r0_first: got %0h at %0t", req_ready, $time);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      tick();
      rand_cycle(1'b1);
    end
    for (int c = 0; c < 300; c++) begin
      tick();
      rand_cycle(1'b0);
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL drain_idle: model still busy at %0t", $time);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
